// File: rtl/two_line_display_driver.sv
// rtl/two_line_display_driver.sv - two-wire display command sender: clk/8 bit timing, fixed init ROM
// Every output is a flop loaded from next-state decode, so the pins never glitch.
module two_line_display_driver #(
  parameter int NUM_BYTES = 4
) (
  input  logic clk,
  input  logic rst_clk,
  input  logic rst_driver,
  input  logic start,
  output logic rst_low,
  output logic data,
  output logic clk_low,
  output logic scl
);

  localparam int BW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  typedef enum logic [1:0] {IDLE, START, SHIFT, STOP} state_t;

  state_t          state_q, state_d;
  logic [2:0]      div_cnt_q, div_cnt_d;
  logic [BW-1:0]   byte_idx_q, byte_idx_d;
  logic [2:0]      bit_idx_q, bit_idx_d;
  logic            start_pend_q, start_pend_d;
  logic            rst_low_q, rst_low_d;
  logic            data_q, data_d;
  logic            scl_q, scl_d;
  logic            tick;
  logic [7:0]      cur_byte;

  function automatic logic [7:0] rom_byte(input logic [BW-1:0] idx);
    logic [31:0] i32;
    i32 = 32'(idx);
    case (i32)
      32'd0:   rom_byte = 8'h38;
      32'd1:   rom_byte = 8'h0C;
      32'd2:   rom_byte = 8'h06;
      32'd3:   rom_byte = 8'h01;
      default: rom_byte = 8'h00;
    endcase
  endfunction

  // A divider reset on the last count suppresses the tick, so the bit restarts in place.
  assign tick = (div_cnt_q == 3'd7) && !rst_clk;

  always_comb begin
    div_cnt_d    = rst_clk ? 3'd0 : div_cnt_q + 3'd1;
    state_d      = state_q;
    byte_idx_d   = byte_idx_q;
    bit_idx_d    = bit_idx_q;
    start_pend_d = start_pend_q;
    rst_low_d    = ~rst_driver;

    if (start && state_q == IDLE) start_pend_d = 1'b1;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (start_pend_q) begin
            state_d      = START;
            start_pend_d = 1'b0;
            byte_idx_d   = '0;
            bit_idx_d    = 3'd0;
          end
        end
        START: state_d = SHIFT;
        SHIFT: begin
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
            byte_idx_d = byte_idx_q + BW'(1);
            if (byte_idx_q == BW'(NUM_BYTES - 1)) state_d = STOP;
          end
        end
        STOP:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end

    if (rst_driver) begin
      state_d      = IDLE;
      byte_idx_d   = '0;
      bit_idx_d    = 3'd0;
      start_pend_d = 1'b0;
    end

    cur_byte = rom_byte(byte_idx_d);
    data_d   = 1'b1;
    scl_d    = 1'b1;
    case (state_d)
      START:   data_d = ~div_cnt_d[2];
      SHIFT: begin
        scl_d  = div_cnt_d[2];
        data_d = cur_byte[3'd7 - bit_idx_d];
      end
      STOP:    data_d = div_cnt_d[2];
      default: data_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    div_cnt_q    <= div_cnt_d;
    state_q      <= state_d;
    byte_idx_q   <= byte_idx_d;
    bit_idx_q    <= bit_idx_d;
    start_pend_q <= start_pend_d;
    rst_low_q    <= rst_low_d;
    data_q       <= data_d;
    scl_q        <= scl_d;
  end

  assign rst_low = rst_low_q;
  assign data    = data_q;
  assign scl     = scl_q;
  assign clk_low = div_cnt_q[2];

endmodule

// File: tb/tb_two_line_display_driver.sv
// tb/tb_two_line_display_driver.sv - scoreboard bench for two_line_display_driver
module tb_two_line_display_driver;

  logic clk = 1'b0;
  logic rst_clk, rst_driver, start;
  logic rst_low, data, clk_low, scl;

  two_line_display_driver #(.NUM_BYTES(4)) dut (
    .clk(clk), .rst_clk(rst_clk), .rst_driver(rst_driver), .start(start),
    .rst_low(rst_low), .data(data), .clk_low(clk_low), .scl(scl)
  );

  always #10 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  logic [2:0] tb_cnt = 3'd0;

  bit exp_q[$];
  int starts = 0, stops = 0, bits_this = 0;
  int t_start = 0, t_stop = 0, last_gap = 0;
  logic in_xfer = 1'b0, prev_scl = 1'b1, prev_data = 1'b1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push_xfer();
    logic [7:0] rom [4];
    rom[0] = 8'h38; rom[1] = 8'h0C; rom[2] = 8'h06; rom[3] = 8'h01;
    for (int b = 0; b < 4; b++)
      for (int i = 7; i >= 0; i--) exp_q.push_back(rom[b][i]);
  endtask

  // sel 0 waits on STOP count, sel 1 on START count
  task automatic wait_count(input int sel, input int n, input int budget, input string tag);
    int k = 0;
    while (((sel == 0) ? stops : starts) < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    check_val(tag, ((sel == 0) ? stops : starts) >= n, 1);
  endtask

  always @(posedge clk) begin
    cyc    <= cyc + 1;
    tb_cnt <= rst_clk ? 3'd0 : tb_cnt + 3'd1;
  end

  always @(negedge clk) begin
    if (rst_low !== 1'b1) begin
      in_xfer = 1'b0;
    end else begin
      if (!prev_scl && scl) begin
        if (exp_q.size() == 0) check_val("extra_bit", 1, 0);
        else check_val("bit", data, exp_q.pop_front());
        bits_this++;
      end
      if (prev_scl && scl && prev_data && !data && !in_xfer) begin
        in_xfer   = 1'b1;
        starts++;
        t_start   = cyc;
        bits_this = 0;
        last_gap  = cyc - t_stop;
        check_val("start_phase", tb_cnt, 4);
      end
      if (prev_scl && scl && !prev_data && data) begin
        stops++;
        check_val("xfer_len", cyc - t_start, 264);
        check_val("bits_per_xfer", bits_this, 32);
        t_stop  = cyc;
        in_xfer = 1'b0;
      end
    end
    prev_scl  = scl;
    prev_data = data;
  end

  initial begin
    int bad, p, base;
    rst_clk = 1'b1; rst_driver = 1'b1; start = 1'b0;
    repeat (3) @(negedge clk);

    // divider release pattern and long driver reset hold
    bad = 0;
    for (int i = 0; i < 450; i++) begin
      @(negedge clk);
      if (i < 16) check_val("clk_low", clk_low, ((i % 8) >= 4) ? 1 : 0);
      if (rst_low !== 1'b0 || data !== 1'b1 || scl !== 1'b1) bad++;
      if (i == 0) rst_clk = 1'b0;
      if (i == 449) rst_driver = 1'b0;
    end
    check_val("rst_hold_bad", bad, 0);
    @(negedge clk);
    check_val("rst_low_release", rst_low, 1);
    check_val("idle_data", data, 1);
    check_val("idle_scl", scl, 1);

    // long start level: exactly one transfer
    push_xfer();
    base = starts;
    start = 1'b1;
    repeat (200) @(negedge clk);
    start = 1'b0;
    wait_count(0, 1, 400, "timeout_xfer1");
    repeat (40) @(negedge clk);
    check_val("single_xfer", starts - base, 1);
    check_val("after_data", data, 1);
    check_val("after_scl", scl, 1);
    check_val("q_empty1", exp_q.size(), 0);

    // one-clock pulse at div_cnt 2
    bad = 0;
    while (tb_cnt != 3'd2 && bad < 20) begin @(negedge clk); bad++; end
    push_xfer();
    p = cyc;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_count(1, 2, 40, "timeout_pulse_start");
    check_val("pulse_latency", t_start - p, 10);
    wait_count(0, 2, 400, "timeout_xfer2");
    repeat (20) @(negedge clk);

    // abort during bit 10, then resend from the first byte
    push_xfer();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    bad = 0;
    while (!(in_xfer && bits_this == 10 && tb_cnt == 3'd1) && bad < 300) begin
      @(negedge clk); bad++;
    end
    check_val("reach_bit10", bad < 300, 1);
    base = stops;
    rst_driver = 1'b1;
    @(negedge clk);
    check_val("abort_data", data, 1);
    check_val("abort_scl", scl, 1);
    check_val("abort_rst_low", rst_low, 0);
    rst_driver = 1'b0;
    exp_q.delete();
    repeat (10) @(negedge clk);
    check_val("abort_no_stop", stops - base, 0);
    check_val("abort_idle", {data, scl}, 2'b11);
    push_xfer();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_count(0, base + 1, 400, "timeout_resend");
    repeat (20) @(negedge clk);

    // start held: back-to-back with one idle bit between
    base = starts;
    push_xfer();
    push_xfer();
    start = 1'b1;
    wait_count(1, base + 2, 700, "timeout_b2b_start");
    start = 1'b0;
    check_val("b2b_gap", last_gap, 16);
    wait_count(0, stops + 1, 400, "timeout_b2b_stop");
    repeat (40) @(negedge clk);
    check_val("b2b_count", starts - base, 2);
    check_val("q_empty_end", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
